// File: rtl/table_writer.sv
// Stream-to-table writer: accepts a valid/ready burst of words into a DEPTH-entry
// table at an auto-incrementing address, with a registered random-access read port.
module table_writer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   count_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_e;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                len_ok;
  logic                xfer;

  assign len_ok = (len_i != '0) && (len_i <= DEPTH_L);
  assign xfer   = (state_q == WRITE) && valid_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i && len_ok) state_d = WRITE;
      WRITE:   if (xfer && (rem_q == CNT_ONE)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      WRITE: begin
        ready_o = 1'b1;
        busy_o  = 1'b1;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  // A start outside IDLE never alters the running burst; it only flags an error.
  always_comb begin
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    count_d = count_q;
    err_d   = err_q;
    if (start_i) begin
      if ((state_q == IDLE) && len_ok) begin
        ptr_d   = base_i;
        rem_d   = len_i;
        count_d = '0;
        err_d   = 1'b0;
      end else begin
        err_d   = 1'b1;
      end
    end
    if (xfer) begin
      ptr_d   = ptr_q + PTR_ONE;
      rem_d   = rem_q - CNT_ONE;
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q   <= '0;
      rem_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Table storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (xfer) begin
      mem_q[ptr_q] <= data_i;
    end
  end

  // Read samples the array before this edge's write lands: read-before-write.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;
  assign count_o   = count_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_table_writer.sv
// Self-checking bench for table_writer: table-driven bursts plus hand-written
// sequences for start-while-busy, read-before-write and mid-burst reset.
module tb_table_writer;

  logic        clk_i     = 1'b0;
  logic        rst_i     = 1'b0;
  logic        start_i   = 1'b0;
  logic [7:0]  base_i    = '0;
  logic [8:0]  len_i     = '0;
  logic [31:0] data_i    = '0;
  logic        valid_i   = 1'b0;
  logic [7:0]  rd_addr_i = '0;
  logic        ready_o, busy_o, done_o, err_o;
  logic [31:0] rd_data_o;
  logic [8:0]  count_o;

  int checks   = 0;
  int failures = 0;

  table_writer #(.DATA_W(32), .DEPTH(256), .ADDR_W(8)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .base_i    (base_i),
    .len_i     (len_i),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .count_o   (count_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  len;
    logic [31:0] seed;
    logic [5:0]  vpat;
    logic        exp_err;
    logic [8:0]  exp_count;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb_q[$];
  logic [31:0] mem_m [256];
  bit          written_m [256];
  vec_t        vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic sb_push(input logic [7:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
    mem_m[a]     = d;
    written_m[a] = 1'b1;
  endtask

  task automatic sb_drain(input string tag);
    wr_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      rd_addr_i = e.addr;
      tick();
      check($sformatf("%s_rd_%02h", tag, e.addr), 64'(rd_data_o), 64'(e.data));
    end
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] l);
    start_i = 1'b1;
    base_i  = b;
    len_i   = l;
    tick();
    start_i = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b, input logic [8:0] l, input logic [31:0] seed,
                      input logic [5:0] vpat, input string tag);
    logic [7:0] ptr;
    int sent, c, rdy, early, budget;
    ptr = b; sent = 0; c = 0; rdy = 0; early = 0;
    budget = 8 * int'(l) + 20;
    while (sent < int'(l) && c < budget) begin
      valid_i = vpat[c % 6];
      data_i  = seed + 32'(sent);
      if (ready_o) rdy++;
      if (done_o) early++;
      if (valid_i && ready_o) begin
        sb_push(ptr, data_i);
        ptr++;
        sent++;
      end
      tick();
      c++;
    end
    valid_i = 1'b0;
    check({tag, "_sent"}, 64'(sent), 64'(l));
    check({tag, "_ready_cycles"}, 64'(rdy), 64'(c));
    check({tag, "_early_done"}, 64'(early), 64'(0));
    check({tag, "_done"}, 64'(done_o), 64'(1));
    check({tag, "_done_busy"}, 64'(busy_o), 64'(0));
    check({tag, "_done_ready"}, 64'(ready_o), 64'(0));
    check({tag, "_count"}, 64'(count_o), 64'(l));
    tick();
    check({tag, "_done_pulse"}, 64'(done_o), 64'(0));
    check({tag, "_idle_count"}, 64'(count_o), 64'(l));
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    do_start(v.base, v.len);
    check({tag, "_err"}, 64'(err_o), 64'(v.exp_err));
    if (!v.exp_err) begin
      check({tag, "_busy"}, 64'(busy_o), 64'(1));
      check({tag, "_count0"}, 64'(count_o), 64'(0));
      feed(v.base, v.len, v.seed, v.vpat, tag);
      sb_drain(tag);
    end else begin
      check({tag, "_busy"}, 64'(busy_o), 64'(0));
      check({tag, "_ready"}, 64'(ready_o), 64'(0));
      rd_addr_i = v.base;
      tick();
      if (written_m[v.base]) check({tag, "_unchanged"}, 64'(rd_data_o), 64'(mem_m[v.base]));
    end
    check({tag, "_final_count"}, 64'(count_o), 64'(v.exp_count));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old;
    vec_t extra;
    int dn;

    vecs[0] = '{base: 8'h00, len: 9'd4,   seed: 32'hA0,   vpat: 6'b111111, exp_err: 1'b0, exp_count: 9'd4};
    vecs[1] = '{base: 8'hFE, len: 9'd4,   seed: 32'h11,   vpat: 6'b111111, exp_err: 1'b0, exp_count: 9'd4};
    vecs[2] = '{base: 8'h40, len: 9'd3,   seed: 32'h300,  vpat: 6'b101001, exp_err: 1'b0, exp_count: 9'd3};
    vecs[3] = '{base: 8'h40, len: 9'd0,   seed: 32'h0,    vpat: 6'b111111, exp_err: 1'b1, exp_count: 9'd3};
    vecs[4] = '{base: 8'h41, len: 9'd257, seed: 32'h0,    vpat: 6'b111111, exp_err: 1'b1, exp_count: 9'd3};
    vecs[5] = '{base: 8'h10, len: 9'd256, seed: 32'h1000, vpat: 6'b110111, exp_err: 1'b0, exp_count: 9'd256};

    rst_i = 1'b0;
    repeat (2) tick();
    check("rst_ready", 64'(ready_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_err", 64'(err_o), 64'(0));
    check("rst_count", 64'(count_o), 64'(0));
    check("rst_rd_data", 64'(rd_data_o), 64'(0));
    rst_i = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // start_i during an active burst is flagged but otherwise ignored
    do_start(8'h20, 9'd2);
    check("a_busy", 64'(busy_o), 64'(1));
    valid_i = 1'b1; data_i = 32'h5000;
    start_i = 1'b1; base_i = 8'h99; len_i = 9'd5;
    sb_push(8'h20, 32'h5000);
    tick();
    start_i = 1'b0;
    check("a_err", 64'(err_o), 64'(1));
    check("a_still_busy", 64'(busy_o), 64'(1));
    data_i = 32'h5001;
    sb_push(8'h21, 32'h5001);
    tick();
    valid_i = 1'b0;
    check("a_done", 64'(done_o), 64'(1));
    check("a_count", 64'(count_o), 64'(2));
    tick();
    check("a_idle_busy", 64'(busy_o), 64'(0));
    check("a_done_pulse", 64'(done_o), 64'(0));
    sb_drain("a");
    rd_addr_i = 8'h99;
    tick();
    check("a_99_untouched", 64'(rd_data_o), 64'(mem_m[8'h99]));

    // read-before-write on the live write address, then a start in the DONE cycle
    do_start(8'h40, 9'd2);
    check("b_err_cleared", 64'(err_o), 64'(0));
    old = mem_m[8'h40];
    rd_addr_i = 8'h40; valid_i = 1'b1; data_i = 32'h7000;
    sb_push(8'h40, 32'h7000);
    tick();
    check("b_rbw_old", 64'(rd_data_o), 64'(old));
    data_i = 32'h7001;
    sb_push(8'h41, 32'h7001);
    tick();
    valid_i = 1'b0;
    check("b_rbw_new", 64'(rd_data_o), 64'(32'h7000));
    check("b_done", 64'(done_o), 64'(1));
    start_i = 1'b1; base_i = 8'h00; len_i = 9'd4;
    tick();
    start_i = 1'b0;
    check("b_done_start_err", 64'(err_o), 64'(1));
    check("b_done_start_busy", 64'(busy_o), 64'(0));
    check("b_count", 64'(count_o), 64'(2));
    sb_drain("b");

    // reset asserted after two of five words
    do_start(8'h60, 9'd5);
    valid_i = 1'b1; data_i = 32'h9000;
    sb_push(8'h60, 32'h9000);
    tick();
    data_i = 32'h9001;
    sb_push(8'h61, 32'h9001);
    tick();
    valid_i = 1'b0;
    rst_i = 1'b0;
    #1;
    check("c_rst_ready", 64'(ready_o), 64'(0));
    check("c_rst_busy", 64'(busy_o), 64'(0));
    check("c_rst_done", 64'(done_o), 64'(0));
    check("c_rst_err", 64'(err_o), 64'(0));
    check("c_rst_count", 64'(count_o), 64'(0));
    check("c_rst_rd_data", 64'(rd_data_o), 64'(0));
    tick();
    rst_i = 1'b1;
    dn = 0;
    repeat (4) begin
      tick();
      if (done_o || busy_o) dn++;
    end
    check("c_no_done", 64'(dn), 64'(0));
    sb_drain("c");
    rd_addr_i = 8'h62;
    tick();
    check("c_62_untouched", 64'(rd_data_o), 64'(mem_m[8'h62]));
    extra = '{base: 8'h60, len: 9'd3, seed: 32'hA000, vpat: 6'b111111, exp_err: 1'b0, exp_count: 9'd3};
    apply_vec(extra, "c_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
